// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the core memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

    // Owner of a memory slot; NONE marks writes and idle cycles
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LD   = 2'd1,
        TAG_LS   = 2'd2,
        TAG_IF   = 2'd3
    } tag_t;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } rr_last_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; 'hold' suppresses grants and freezes the pointer.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic hold,
    output logic gnt_a,
    output logic gnt_b
);

    rr_last_t last, last_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= LAST_A;
        end else begin
            last <= last_next;
        end
    end

    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        last_next = last;
        if (!hold) begin
            if (req_a && (!req_b || last == LAST_B)) begin
                gnt_a     = 1'b1;
                last_next = LAST_A;
            end else if (req_b) begin
                gnt_b     = 1'b1;
                last_next = LAST_B;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader priority, LSU/IF round-robin,
// read data routed back through a MEM_LAT-deep owner tag pipeline.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [3:0]        ld_wstrb,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_wstrb,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    tag_t new_tag;
    tag_t resp_tag;
    tag_t pipe [MEM_LAT];

    // Reset is folded into the grant path so nothing is granted while held in reset
    assign ld_gnt = ld_req & rst;

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_a (ls_req),
        .req_b (if_req),
        .hold  (ld_req | ~rst),
        .gnt_a (ls_gnt),
        .gnt_b (if_gnt)
    );

    assign mem_en = ld_gnt | ls_gnt | if_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        new_tag   = TAG_NONE;
        if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_wstrb = ld_wstrb;
            new_tag   = ld_we ? TAG_NONE : TAG_LD;
        end else if (ls_gnt) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_wstrb = ls_wstrb;
            new_tag   = ls_we ? TAG_NONE : TAG_LS;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            new_tag   = TAG_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                pipe[i] <= TAG_NONE;
            end
        end else begin
            pipe[0] <= new_tag;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign resp_tag  = pipe[MEM_LAT-1];
    assign ld_rvalid = (resp_tag == TAG_LD);
    assign ls_rvalid = (resp_tag == TAG_LS);
    assign if_rvalid = (resp_tag == TAG_IF);
    assign ld_rdata  = ld_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            busy = busy | (pipe[i] != TAG_NONE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed sequences and random
// traffic checked against a queue-based reference model and shadow memory.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0;
    logic [3:0]  ld_wstrb = '0;
    logic        ld_gnt, ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic [3:0]  ls_wstrb = '0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_wstrb(ld_wstrb), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory array driven by the DUT's port, with LAT-cycle read latency
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [LAT];
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    // Reference model state: owners 1=LD 2=LS 3=IF
    typedef struct {
        int unsigned due;
        int          owner;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] ref_mem [256];
    logic        last_ls;
    int unsigned cyc;
    int          total = 0;
    int          bad = 0;

    logic [2:0]  s_gnt;
    logic [3:0]  s_wstrb;
    logic        s_if_rv, s_ls_rv, s_busy;
    logic [31:0] s_if_rd, s_ls_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        int          owner;
        int          rv_owner;
        logic [31:0] rv_data;
        logic [31:0] ea, ed;
        logic        ew;
        logic [3:0]  es;
        owner = 0;
        if (ld_req) owner = 1;
        else if (ls_req && if_req) owner = last_ls ? 3 : 2;
        else if (ls_req) owner = 2;
        else if (if_req) owner = 3;
        ea = '0; ed = '0; ew = 1'b0; es = '0;
        case (owner)
            1: begin ea = ld_addr; ed = ld_wdata; ew = ld_we; es = ld_wstrb; end
            2: begin ea = ls_addr; ed = ls_wdata; ew = ls_we; es = ls_wstrb; end
            3: ea = if_addr;
            default: ;
        endcase
        chk("ld_gnt", 32'(ld_gnt), 32'(owner == 1));
        chk("ls_gnt", 32'(ls_gnt), 32'(owner == 2));
        chk("if_gnt", 32'(if_gnt), 32'(owner == 3));
        chk("mem_en", 32'(mem_en), 32'(owner != 0));
        chk("mem_we", 32'(mem_we), 32'(ew));
        chk("mem_addr", mem_addr, ea);
        if (ew) begin
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(es));
        end
        chk("busy", 32'(busy), 32'(rq.size() != 0));
        rv_owner = 0;
        rv_data  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rv_owner = rq[0].owner;
            rv_data  = rq[0].data;
            rq.delete(0);
        end
        chk("ld_rvalid", 32'(ld_rvalid), 32'(rv_owner == 1));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(rv_owner == 2));
        chk("if_rvalid", 32'(if_rvalid), 32'(rv_owner == 3));
        chk("ld_rdata", ld_rdata, rv_owner == 1 ? rv_data : 32'h0);
        chk("ls_rdata", ls_rdata, rv_owner == 2 ? rv_data : 32'h0);
        chk("if_rdata", if_rdata, rv_owner == 3 ? rv_data : 32'h0);
        s_gnt = {ld_gnt, ls_gnt, if_gnt};
        s_wstrb = mem_wstrb;
        s_if_rv = if_rvalid; s_if_rd = if_rdata;
        s_ls_rv = ls_rvalid; s_ls_rd = ls_rdata;
        s_busy  = busy;
        if (owner != 0) begin
            if (ew) begin
                for (int b = 0; b < 4; b++)
                    if (es[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
            end else begin
                rq.push_back('{cyc + LAT, owner, ref_mem[ea[9:2]]});
            end
            if (owner == 2) last_ls = 1'b1;
            if (owner == 3) last_ls = 1'b0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_req = 1'b0; ls_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_gnt", 32'({ld_gnt, ls_gnt, if_gnt}), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_rvalid", 32'({ld_rvalid, ls_rvalid, if_rvalid}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rq.delete();
        last_ls = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    typedef struct {
        logic       ld;
        logic       ls;
        logic       ifr;
        logic [2:0] gnt;
    } vec_t;

    vec_t        vecs [10];
    logic [2:0]  g_rec [16];
    logic        rv_rec [16];
    logic        rb_rec [16];
    int          cnt;
    logic        ld_p, ls_p, if_p;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        cyc = 0;
        last_ls = 1'b1;
        @(posedge clk);
        #1;

        // Arbitration vector table, all transactions writes except IF
        vecs[0] = '{1'b0, 1'b1, 1'b1, 3'b001};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 3'b010};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 3'b100};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b001};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 3'b010};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3'b001};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'b000};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 3'b010};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 3'b100};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 3'b001};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ld_req = vecs[i].ld; ld_we = 1'b1; ld_addr = 32'h200 + 32'(i * 4);
            ld_wdata = $urandom; ld_wstrb = 4'hF;
            ls_req = vecs[i].ls; ls_we = 1'b1; ls_addr = 32'h300 + 32'(i * 4);
            ls_wdata = $urandom; ls_wstrb = 4'hF;
            if_req = vecs[i].ifr; if_addr = 32'(i * 4);
            tick();
            chk("vec_gnt", 32'(s_gnt), 32'(vecs[i].gnt));
        end
        idle();
        for (int i = 0; i < LAT + 1; i++) tick();

        // Reset while an IF read is in flight
        do_reset();
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        chk("t1_grant", 32'(s_gnt), 32'h1);
        do_reset();
        cnt = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            if (s_if_rv) cnt++;
        end
        chk("t1_no_rvalid", 32'(cnt), 32'h0);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; if_req = 1'b1; if_addr = 32'h20;
        tick();
        chk("t1_tie_to_if", 32'(s_gnt), 32'h1);
        idle();
        for (int i = 0; i < LAT + 1; i++) tick();

        // Sustained LSU/IF tie alternates and responses keep grant order
        do_reset();
        for (int n = 0; n < 4 + LAT; n++) begin
            ls_req = (n < 4); ls_we = 1'b0; ls_addr = 32'h10;
            if_req = (n < 4); if_addr = 32'h20;
            tick();
            g_rec[n] = s_gnt;
            rv_rec[n] = s_if_rv;
            rb_rec[n] = s_ls_rv;
        end
        for (int k = 0; k < 4; k++) begin
            chk("t2_grant", 32'(g_rec[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("t2_if_rv", 32'(rv_rec[k + LAT]), 32'(k % 2 == 0));
            chk("t2_ls_rv", 32'(rb_rec[k + LAT]), 32'(k % 2 == 1));
        end
        idle();

        // Loader override leaves round-robin pointer alone
        do_reset();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEADBEEF; ld_wstrb = 4'hF;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        chk("t3_ld_only", 32'(s_gnt), 32'h4);
        ld_req = 1'b0;
        tick();
        chk("t3_if_after_ld", 32'(s_gnt), 32'h1);
        if_req = 1'b0;
        tick();
        chk("t3_ls_grant", 32'(s_gnt), 32'h2);
        ls_req = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        chk("t3_ls_rv", 32'(s_ls_rv), 32'h1);
        chk("t3_ls_rdata", s_ls_rd, 32'hDEADBEEF);

        // Byte-strobed LSU write, then IF read back
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h0000AB00; ls_wstrb = 4'b0010;
        tick();
        chk("t4_wstrb", 32'(s_wstrb), 32'h2);
        ls_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        if_req = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        chk("t4_if_rv", 32'(s_if_rv), 32'h1);
        chk("t4_byte1", 32'(s_if_rd[15:8]), 32'hAB);

        // Back-to-back IF reads are pipelined
        for (int n = 0; n < LAT + 4; n++) begin
            if_req = (n < 3); if_addr = 32'(n * 4);
            tick();
            rv_rec[n] = s_if_rv;
            rb_rec[n] = s_busy;
        end
        for (int n = 1; n < LAT + 4; n++) begin
            chk("t5_if_rv", 32'(rv_rec[n]), 32'(n >= LAT && n <= LAT + 2));
            chk("t5_busy", 32'(rb_rec[n]), 32'(n <= LAT + 2));
        end

        // LSU write then read of the same word
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h12345678; ls_wstrb = 4'hF;
        tick();
        ls_we = 1'b0;
        tick();
        ls_req = 1'b0;
        for (int n = 2; n <= LAT + 1; n++) begin
            tick();
            if (n == LAT) chk("t6_write_no_rv", 32'(s_ls_rv), 32'h0);
        end
        chk("t6_read_rv", 32'(s_ls_rv), 32'h1);
        chk("t6_read_data", s_ls_rd, 32'h12345678);

        // Random traffic against the reference model
        ld_p = 1'b0; ls_p = 1'b0; if_p = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                ld_p = 1'b0; ls_p = 1'b0; if_p = 1'b0;
            end
            if (!ld_p && $urandom_range(0, 7) == 0) begin
                ld_p = 1'b1; ld_we = 1'($urandom_range(0, 1));
                ld_addr = 32'($urandom_range(0, 255)) << 2;
                ld_wdata = $urandom; ld_wstrb = 4'($urandom);
            end
            if (!ls_p && $urandom_range(0, 1) == 0) begin
                ls_p = 1'b1; ls_we = 1'($urandom_range(0, 1));
                ls_addr = 32'($urandom_range(0, 255)) << 2;
                ls_wdata = $urandom; ls_wstrb = 4'($urandom);
            end
            if (!if_p && $urandom_range(0, 1) == 0) begin
                if_p = 1'b1;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            ld_req = ld_p; ls_req = ls_p; if_req = if_p;
            tick();
            if (s_gnt[2]) ld_p = 1'b0;
            if (s_gnt[1]) ls_p = 1'b0;
            if (s_gnt[0]) if_p = 1'b0;
        end
        idle();
        for (int i = 0; i < LAT + 1; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
